cache_arbiter: RTL

- Shares the single cacheline-wide physical memory port between the I-cache miss path and the D-cache miss/writeback path.
- Sits below both caches and above the cacheline adaptor.
- Accepts one line transaction at a time and latches the winning request's address and write data.
- Drives the memory port and returns the response only to the granted cache.
- Uses round-robin arbitration on simultaneous requests so neither cache starves.

---
 rtl/cache_arbiter_if.sv | 30 +++
 rtl/cache_arbiter.sv | 64 ++++++
 2 files changed

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: line-transaction bus joining both caches, the arbiter and the memory port
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one line-wide memory port between I-cache and D-cache
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst,
  cache_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} state_t;
  state_t            r_state, w_next;
  logic              r_last_d, r_i_resp, r_d_resp;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata, r_i_rdata, r_d_rdata;
  logic              w_d_req, w_grant_d, w_done;
  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
  assign w_done    = bus.mem_resp & (r_state != IDLE);
  // state register; reset abandons any in-flight memory transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // arbitrate in IDLE (a combined read+write is served as a writeback), hold until memory completes
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:             w_next = w_grant_d ? (bus.d_write ? D_WR : D_RD) : (bus.i_read ? I_RD : IDLE);
      I_RD, D_RD, D_WR: w_next = w_done ? IDLE : r_state;
      default:          w_next = IDLE;
    endcase
  end
  // latch the winner's request at grant, pulse the granted side's resp and capture read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_d  <= 1'b0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_resp <= w_done & (r_state == I_RD);
      r_d_resp <= w_done & (r_state != I_RD);
      if (w_done && r_state == I_RD) r_i_rdata <= bus.mem_rdata;
      if (w_done && r_state == D_RD) r_d_rdata <= bus.mem_rdata;
      if (r_state == IDLE && w_next != IDLE) begin
        r_addr   <= w_grant_d ? bus.d_addr : bus.i_addr;
        r_wdata  <= (w_grant_d & bus.d_write) ? bus.d_wdata : '0;
        r_last_d <= w_grant_d;
      end
    end
  end
  assign bus.mem_read  = (r_state == I_RD) || (r_state == D_RD);
  assign bus.mem_write = (r_state == D_WR);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = (r_state == D_WR) ? r_wdata : '0;
  assign bus.i_resp    = r_i_resp;
  assign bus.d_resp    = r_d_resp;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  a_rw_excl: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));
endmodule
